// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the multiply/divide engine:
//   - ALU opcodes the engine acts on (shared with the combinational ALU)
//   - FSM state encoding
package mul_div_unit_pkg;

  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_RUN = 3'd1,
    ST_DIV_RUN = 3'd2,
    ST_FIXUP   = 3'd3,
    ST_DONE    = 3'd4
  } md_state_e;

endpackage

// File: rtl/mul_div_negate.sv
// mul_div_negate
//   W-bit conditional two's-complement: y = neg ? -a : a.
// Ports:
//   neg  in   1  negate request
//   a    in   W  operand
//   y    out  W  result
module mul_div_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  // Select the operand or its two's complement
  always_comb begin
    if (neg) begin
      y = (~a) + W'(1);
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on
//   magnitudes) engine. One iteration per clock, REG_SIZE iterations, then a
//   FIXUP cycle and a DONE cycle; done pulses REG_SIZE+2 edges after the
//   accepting edge for every operation type.
// Ports:
//   clk          in   1         system clock, rising edge
//   reset_n      in   1         asynchronous active-low reset
//   ctrl_sig     in   4         ALU code; only MUL (1000) / DIV (1001) accepted
//   start        in   1         request, sampled with ctrl_sig and operands
//   y_data_in    in   REG_SIZE  multiplicand / dividend
//   bus_data_in  in   REG_SIZE  multiplier / divisor
//   busy         out  1         operation in flight
//   done         out  1         one-cycle result-valid pulse
//   z_hi_out     out  REG_SIZE  MUL: product high half; DIV: remainder
//   z_lo_out     out  REG_SIZE  MUL: product low half;  DIV: quotient
//   div_by_zero  out  1         DIV with zero divisor; held until next start
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int REG_SIZE = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          ctrl_sig,
  input  logic                start,
  input  logic [REG_SIZE-1:0] y_data_in,
  input  logic [REG_SIZE-1:0] bus_data_in,
  output logic                busy,
  output logic                done,
  output logic [REG_SIZE-1:0] z_hi_out,
  output logic [REG_SIZE-1:0] z_lo_out,
  output logic                div_by_zero
);

  localparam int N = REG_SIZE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_SIZE - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N:0]       acc_q, acc_d;      // Booth accumulator / partial remainder
  logic [N-1:0]     q_q, q_d;          // multiplier / quotient shift register
  logic             qm1_q, qm1_d;      // Booth q(-1)
  logic [N:0]       m_q, m_d;          // multiplicand (sign-ext) / |divisor|
  logic [N-1:0]     y_q, y_d;          // raw dividend, kept for div-by-zero
  logic             y_neg_q, y_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             is_div_q, is_div_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [N-1:0]     z_hi_q, z_hi_d;
  logic [N-1:0]     z_lo_q, z_lo_d;

  logic [N-1:0] y_abs_s, b_abs_s, quot_fix_s, rem_fix_s;
  logic [N:0]   booth_sum_s, rem_sh_s;
  logic         accept_s;

  // Magnitudes at capture and sign restoration at fixup
  mul_div_negate #(.W(N)) u_abs_y   (.neg(y_data_in[N-1]),    .a(y_data_in),        .y(y_abs_s));
  mul_div_negate #(.W(N)) u_abs_b   (.neg(bus_data_in[N-1]),  .a(bus_data_in),      .y(b_abs_s));
  mul_div_negate #(.W(N)) u_fix_quo (.neg(y_neg_q ^ b_neg_q), .a(q_q),              .y(quot_fix_s));
  mul_div_negate #(.W(N)) u_fix_rem (.neg(y_neg_q),           .a(acc_q[N-1:0]),     .y(rem_fix_s));

  assign accept_s = start && ((ctrl_sig == ALU_MUL) || (ctrl_sig == ALU_DIV));

  // Next-state and datapath computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    q_d        = q_q;
    qm1_d      = qm1_q;
    m_d        = m_q;
    y_d        = y_q;
    y_neg_d    = y_neg_q;
    b_neg_d    = b_neg_q;
    is_div_d   = is_div_q;
    dbz_pend_d = dbz_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    z_hi_d     = z_hi_q;
    z_lo_d     = z_lo_q;
    booth_sum_s = acc_q;
    rem_sh_s    = {acc_q[N-1:0], q_q[N-1]};

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          busy_d     = 1'b1;
          dbz_d      = 1'b0;
          cnt_d      = '0;
          acc_d      = '0;
          qm1_d      = 1'b0;
          y_d        = y_data_in;
          y_neg_d    = y_data_in[N-1];
          b_neg_d    = bus_data_in[N-1];
          is_div_d   = (ctrl_sig == ALU_DIV);
          if (ctrl_sig == ALU_DIV) begin
            q_d        = y_abs_s;
            m_d        = {1'b0, b_abs_s};
            dbz_pend_d = (bus_data_in == '0);
            state_d    = ST_DIV_RUN;
          end else begin
            q_d        = bus_data_in;
            m_d        = {y_data_in[N-1], y_data_in};
            dbz_pend_d = 1'b0;
            state_d    = ST_MUL_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MUL_RUN: begin
        case ({q_q[0], qm1_q})
          2'b01:   booth_sum_s = acc_q + m_q;
          2'b10:   booth_sum_s = acc_q - m_q;
          default: booth_sum_s = acc_q;
        endcase
        // Arithmetic shift right of {acc, q, q-1}
        acc_d = {booth_sum_s[N], booth_sum_s[N:1]};
        q_d   = {booth_sum_s[0], q_q[N-1:1]};
        qm1_d = q_q[0];
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DIV_RUN: begin
        // Restoring step: subtract only when the shifted remainder covers |divisor|
        if (rem_sh_s >= m_q) begin
          acc_d = rem_sh_s - m_q;
          q_d   = {q_q[N-2:0], 1'b1};
        end else begin
          acc_d = rem_sh_s;
          q_d   = {q_q[N-2:0], 1'b0};
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_FIXUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIXUP: begin
        if (is_div_q && dbz_pend_q) begin
          acc_d = {y_q[N-1], y_q};
          q_d   = '1;
        end else if (is_div_q) begin
          acc_d = {rem_fix_s[N-1], rem_fix_s};
          q_d   = quot_fix_s;
        end else begin
          acc_d = acc_q;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        z_hi_d  = acc_q[N-1:0];
        z_lo_d  = q_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dbz_d   = dbz_pend_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      y_q        <= '0;
      y_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      is_div_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      y_q        <= y_d;
      y_neg_q    <= y_neg_d;
      b_neg_q    <= b_neg_d;
      is_div_q   <= is_div_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      z_hi_q     <= z_hi_d;
      z_lo_q     <= z_lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign z_hi_out    = z_hi_q;
  assign z_lo_out    = z_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed self-checking bench for mul_div_unit with hand-computed vectors.
module tb_mul_div_unit;

  logic        clk;
  logic        reset_n;
  logic [3:0]  ctrl_sig;
  logic        start;
  logic [31:0] y_data_in;
  logic [31:0] bus_data_in;
  logic        busy;
  logic        done;
  logic [31:0] z_hi_out;
  logic [31:0] z_lo_out;
  logic        div_by_zero;

  int checks;
  int errors;
  int lat;
  int ndone;
  int nbusy;
  logic [31:0] cap_hi;
  logic [31:0] cap_lo;

  mul_div_unit #(.REG_SIZE(32), .CNT_W(6)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ctrl_sig    (ctrl_sig),
    .start       (start),
    .y_data_in   (y_data_in),
    .bus_data_in (bus_data_in),
    .busy        (busy),
    .done        (done),
    .z_hi_out    (z_hi_out),
    .z_lo_out    (z_lo_out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, check busy rises after the accepting edge, then wait
  // (bounded) for done. lat = edges after the accepting edge until done seen.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] y,
                        input logic [31:0] b, output int l);
    @(negedge clk);
    ctrl_sig = c; y_data_in = y; bus_data_in = b; start = 1'b1;
    @(posedge clk);
    l = 0;
    @(negedge clk);
    start = 1'b0; ctrl_sig = 4'b0000;
    chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
    while (!done && l < 100) begin
      @(posedge clk);
      l++;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; start = 1'b0; ctrl_sig = 4'b0000;
    y_data_in = 32'd0; bus_data_in = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("rst_z",    {z_hi_out, z_lo_out}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -3
    run_op("mul1", 4'b1000, 32'd7, 32'hFFFF_FFFD, lat);
    chk("mul1_lat", 64'(lat), 64'd34);
    chk("mul1_z", {z_hi_out, z_lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul1_busy_drop", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("mul1_done_pulse", {63'd0, done}, 64'd0);
    chk("mul1_hold", {z_hi_out, z_lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // MUL min * min
    run_op("mul2", 4'b1000, 32'h8000_0000, 32'h8000_0000, lat);
    chk("mul2_lat", 64'(lat), 64'd34);
    chk("mul2_z", {z_hi_out, z_lo_out}, 64'h4000_0000_0000_0000);

    // MUL 0xFFFF * 0xFFFF
    run_op("mul3", 4'b1000, 32'h0000_FFFF, 32'h0000_FFFF, lat);
    chk("mul3_z", {z_hi_out, z_lo_out}, 64'h0000_0000_FFFE_0001);

    // DIV -7 / 2
    run_op("div1", 4'b1001, 32'hFFFF_FFF9, 32'd2, lat);
    chk("div1_lat", 64'(lat), 64'd34);
    chk("div1_z", {z_hi_out, z_lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV 100 / -7
    run_op("div2", 4'b1001, 32'd100, 32'hFFFF_FFF9, lat);
    chk("div2_z", {z_hi_out, z_lo_out}, 64'h0000_0002_FFFF_FFF2);

    // DIV overflow: min / -1
    run_op("div_ovf", 4'b1001, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk("div_ovf_z", {z_hi_out, z_lo_out}, 64'h0000_0000_8000_0000);
    chk("div_ovf_dbz", {63'd0, div_by_zero}, 64'd0);

    // DIV 5 / 0
    run_op("dbz", 4'b1001, 32'd5, 32'd0, lat);
    chk("dbz_lat", 64'(lat), 64'd34);
    chk("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    chk("dbz_z", {z_hi_out, z_lo_out}, 64'h0000_0005_FFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("dbz_flag_hold", {63'd0, div_by_zero}, 64'd1);
    // Next MUL clears the flag
    run_op("mul4", 4'b1000, 32'd3, 32'd5, lat);
    chk("mul4_dbz_clr", {63'd0, div_by_zero}, 64'd0);
    chk("mul4_z", {z_hi_out, z_lo_out}, 64'd15);

    // Starts during busy are ignored
    @(negedge clk);
    ctrl_sig = 4'b1000; y_data_in = 32'd6; bus_data_in = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0; lat = 0; cap_hi = 32'd0; cap_lo = 32'd0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        lat = i;
        cap_hi = z_hi_out;
        cap_lo = z_lo_out;
      end
      start = (i == 5 || i == 20);
      ctrl_sig = 4'b1001; y_data_in = 32'd100; bus_data_in = 32'd3;
    end
    start = 1'b0; ctrl_sig = 4'b0000;
    chk("busy_ign_ndone", 64'(ndone), 64'd1);
    chk("busy_ign_lat", 64'(lat), 64'd34);
    chk("busy_ign_z", {cap_hi, cap_lo}, 64'd42);

    // Unsupported opcode in IDLE is ignored
    @(negedge clk);
    ctrl_sig = 4'b0010; y_data_in = 32'd9; bus_data_in = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("bad_op_done", 64'(ndone), 64'd0);
    chk("bad_op_busy", 64'(nbusy), 64'd0);
    chk("bad_op_z", {z_hi_out, z_lo_out}, 64'd42);

    // Reset in the middle of a DIV
    @(negedge clk);
    ctrl_sig = 4'b1001; y_data_in = 32'd100; bus_data_in = 32'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_z", {z_hi_out, z_lo_out}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    run_op("mul5", 4'b1000, 32'd3, 32'd4, lat);
    chk("mul5_lat", 64'(lat), 64'd34);
    chk("mul5_z", {z_hi_out, z_lo_out}, 64'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
